// File: rtl/nanov_shift_seq.sv
// Bit-serial shift sequencer: accepts one SLL/SRL/SRA request, emits the result LSB-first over
// 32 cycles, then holds the assembled word. Define NANOV_SHIFT_SEQ_BYPASS_EN to skip b==0 shifts.
module nanov_shift_seq #(
    parameter bit CHECK_OP = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [4:0]  in_b,
    output logic        bit_valid,
    output logic        bit_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_d,
    output logic        out_err
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [4:0]  b_q;
    logic [31:0] a_q;
    logic [31:0] res_q;
    logic        right_q;
    logic        fill_q;
    logic        err_q;

    logic        legal;
    logic        bypass;
    logic [5:0]  sum;
    logic        in_range;
    logic        ser_bit;

    assign legal = (in_op == 4'b0001) || (in_op == 4'b0101) || (in_op == 4'b1101);

`ifdef NANOV_SHIFT_SEQ_BYPASS_EN
    assign bypass = legal && (in_b == 5'd0);
`else
    assign bypass = 1'b0;
`endif

    // Carry out of c+b marks the fill region for right shifts.
    assign sum      = {1'b0, cnt_q} + {1'b0, b_q};
    assign in_range = right_q ? ~sum[5] : (cnt_q >= b_q);
    assign ser_bit  = in_range ? (right_q ? a_q[b_q] : a_q[0]) : (right_q & fill_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        bit_valid = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = bypass ? StDone : StRun;
                end
            end
            StRun: begin
                bit_valid = 1'b1;
                if (cnt_q == 5'd31) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
        end
    end

    assign bit_out = bit_valid & ser_bit;
    assign out_d   = out_valid ? res_q : 32'd0;
    assign out_err = out_valid & err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= 5'd0;
            b_q     <= 5'd0;
            a_q     <= 32'd0;
            res_q   <= 32'd0;
            right_q <= 1'b0;
            fill_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (flush) begin
            cnt_q <= 5'd0;
            res_q <= 32'd0;
            err_q <= 1'b0;
        end else if (state_q == StIdle) begin
            if (in_valid) begin
                a_q     <= in_a;
                b_q     <= in_b;
                right_q <= in_op[2];
                fill_q  <= in_op[3] & in_a[31];
                cnt_q   <= 5'd0;
                err_q   <= CHECK_OP & ~legal;
                res_q   <= bypass ? in_a : 32'd0;
            end
        end else if (state_q == StRun) begin
            if (in_range) begin
                a_q <= a_q >> 1;
            end
            res_q <= {ser_bit, res_q[31:1]};
            cnt_q <= cnt_q + 5'd1;
        end
    end

endmodule

// File: tb/tb_nanov_shift_seq.sv
// Scoreboard bench for nanov_shift_seq: stimulus pushes expected results, a negedge monitor
// checks result word, error flag, serial bit stream and accept-to-valid latency.
module tb_nanov_shift_seq;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [4:0]  in_b;
    logic        bit_valid;
    logic        bit_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_d;
    logic        out_err;

    nanov_shift_seq dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .bit_valid (bit_valid),
        .bit_out   (bit_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .out_err   (out_err)
    );

    typedef struct {
        logic [31:0] d;
        logic        err;
        int          lat;
        int          nb;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          negn = 0;
    int          acc_n = 0;
    int          nbits = 0;
    logic [31:0] bits_got;
    logic        ov_prev = 1'b0;
    bit          rand_bp = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit is_legal(input logic [3:0] op);
        return (op == 4'd1) || (op == 4'd5) || (op == 4'd13);
    endfunction

    // Shift semantics straight from the op table; illegal ops decode by op[2]/op[3].
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [4:0] b);
        if (!op[2]) return a << b;
        if (op[3]) return $unsigned($signed(a) >>> b);
        return a >> b;
    endfunction

    function automatic bit takes_bypass(input logic [3:0] op, input logic [4:0] b);
`ifdef NANOV_SHIFT_SEQ_BYPASS_EN
        return is_legal(op) && (b == 5'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: everything sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            negn++;
            if (!rstn) begin
                ov_prev = 1'b0;
                nbits   = 0;
            end else begin
                if (bit_valid) begin
                    if (nbits < 32) bits_got[nbits] = bit_out;
                    nbits++;
                end
                if (out_valid && !ov_prev) begin
                    if (q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected out_valid: got out_d 0x%08h, expected none",
                                 out_d);
                    end else begin
                        chk("latency", 32'(negn - acc_n), 32'(q[0].lat));
                    end
                end
                if (out_valid && out_ready && q.size() > 0) begin
                    e = q.pop_front();
                    chk("out_d", out_d, e.d);
                    chk("out_err", {31'd0, out_err}, {31'd0, e.err});
                    chk("bit count", 32'(nbits), 32'(e.nb));
                    if (e.nb == 32) chk("bit stream", bits_got, e.d);
                end
                ov_prev = out_valid & ~out_ready;
                if (in_valid && in_ready && !flush) begin
                    acc_n = negn;
                    nbits = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called and returns at posedge+#1.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [4:0] b,
                         input bit push);
        exp_t e;
        int   w;
        if (push) begin
            e.d   = model(op, a, b);
            e.err = !is_legal(op);
            e.lat = takes_bypass(op, b) ? 1 : 33;
            e.nb  = takes_bypass(op, b) ? 0 : 32;
            q.push_back(e);
        end
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (w = 0; w < 300; w++) begin
            @(negedge clk);
            if (in_ready && !flush) break;
        end
        if (w == 300) begin
            vectors++;
            miscompares++;
            $display("FAIL accept timeout: got in_ready 0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        for (w = 0; w < 300; w++) begin
            if (in_ready && q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (w == 300) begin
            vectors++;
            miscompares++;
            $display("FAIL idle timeout: got %0d pending results, expected 0", q.size());
        end
    endtask

    initial begin
        logic [31:0] exp_bp;
        int          w;
        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 4'd0;
        in_a      = 32'd0;
        in_b      = 5'd0;
        out_ready = 1'b1;
        #1;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset bit_valid", {31'd0, bit_valid}, 32'd0);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_d", out_d, 32'd0);
        chk("reset out_err", {31'd0, out_err}, 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        issue(4'b0001, 32'h0000_0001, 5'd31, 1'b1);
        wait_idle();
        issue(4'b0101, 32'h8000_0000, 5'd4, 1'b1);
        issue(4'b1101, 32'h8000_0000, 5'd4, 1'b1);
        issue(4'b1101, 32'h7FFF_FFF0, 5'd4, 1'b1);
        wait_idle();

        // Backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        exp_bp = model(4'b0101, 32'h1234_5678, 5'd8);
        issue(4'b0101, 32'h1234_5678, 5'd8, 1'b1);
        for (w = 0; w < 100 && !out_valid; w++) begin
            @(posedge clk);
            #1;
        end
        repeat (10) begin
            @(negedge clk);
            chk("bp out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp out_d", out_d, exp_bp);
            chk("bp in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
        issue(4'b0001, 32'h0000_00F0, 5'd3, 1'b1);
        wait_idle();

        // Flush at c=12.
        issue(4'b0101, 32'hFFFF_FFFF, 5'd1, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        chk("flush c12 bit_out", {31'd0, bit_out}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush bit_valid", {31'd0, bit_valid}, 32'd0);
        issue(4'b0001, 32'h0000_0003, 5'd1, 1'b1);
        wait_idle();

        // Asynchronous reset at c=20.
        issue(4'b0001, 32'hA5A5_5A5A, 5'd5, 1'b0);
        repeat (20) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst bit_valid", {31'd0, bit_valid}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst out_d", out_d, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        issue(4'b0011, 32'h0000_0001, 5'd0, 1'b1);
        wait_idle();
        issue(4'b0001, 32'hDEAD_BEEF, 5'd0, 1'b1);
        wait_idle();

        // Randomized requests with random consumer backpressure.
        rand_bp = 1'b1;
        repeat (30) begin
            logic [3:0] op;
            logic [4:0] b;
            case ($urandom_range(0, 4))
                0: op = 4'b0001;
                1: op = 4'b0101;
                2: op = 4'b1101;
                default: op = 4'($urandom_range(0, 15));
            endcase
            b = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            issue(op, $urandom, b, 1'b1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nanov_shift_seq.md
Name: nanov_shift_seq

Overview:
Sequencer for the bit-serial shifter in the nanoV ALU path.
- Accepts one shift request (op, 32-bit operand, 5-bit amount) over a valid/ready handshake.
- Runs it LSB-first over 32 cycles, one result bit per cycle.
- Presents the assembled 32-bit result, a per-cycle serial bit stream and an illegal-op flag; holds the result until the consumer takes it.

Parameters:
- CHECK_OP, 1: 1 = flag ops other than SLL/SRL/SRA; 0 = decode op[2]/op[3] only, never flag.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous abort: return to IDLE, drop request.
- in_valid  in  1  request valid.
- in_ready  out  1  high in IDLE only.
- in_op  in  4  0001 SLL, 0101 SRL, 1101 SRA.
- in_a  in  32  operand.
- in_b  in  5  shift amount.
- bit_valid  out  1  serial bit valid, high in RUN.
- bit_out  out  1  current result bit; index = counter.
- out_valid  out  1  result valid, high in DONE.
- out_ready  in  1  consumer accepts result.
- out_d  out  32  result.
- out_err  out  1  illegal op, valid with out_valid.

Behaviour:
- Reset (rstn low, async): state IDLE, counter 0, all regs 0.
  - in_ready=1 (IDLE), bit_valid=0, out_valid=0, out_d=0, out_err=0.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - in_valid on an edge latches op, a, b; sets counter=0, result=0, err; next state RUN.
- RUN, per cycle with counter c (0..31):
  - SLL: bit = (c < b) ? 0 : a_orig[c-b].
  - SRL: bit = (c+b < 32) ? a_orig[c+b] : 0.
  - SRA: bit = (c+b < 32) ? a_orig[c+b] : a_orig[31].
  - c+b computed 6 bits wide; carry bit 5 selects fill.
  - Working operand register shifts right by one:
    - SLL: only when c >= b.
    - SRL/SRA: only when c+b < 32.
    - Bit source is a[0] for SLL and a[b] for right shifts of the working register.
  - bit_out=bit, bit_valid=1.
  - Result register shifts right with bit entering at [31].
  - counter increments; at c=31 next state DONE (counter wraps to 0).
- DONE:
  - out_valid=1; out_d and out_err stable.
  - out_ready high -> IDLE at that edge; otherwise hold indefinitely.
  - New request cannot be taken in the same cycle (in_ready=0 in DONE).
- Latency (feature off): accept edge T; bits on cycles T+1..T+32; out_valid from cycle T+33.
  - Throughput: one op per 34 cycles with out_ready tied high.
- flush:
  - Any state -> IDLE next edge; out_valid, bit_valid drop.
  - Result discarded; flush has priority over in_valid and out_ready.
- Illegal op (CHECK_OP=1): op not in {0001, 0101, 1101}.
  - Request is still accepted and run as op[2]? right : left; op[3] selects sign fill.
  - out_err=1 in DONE.
- Reset mid-RUN: immediate IDLE, outputs at reset values; no partial result visible.
- b=0: identity result, full 32 cycles (feature off).

Optional Feature:
- Macro: NANOV_SHIFT_SEQ_BYPASS_EN.
- Defined: a request with in_b==0 and a legal op skips RUN.
  - out_d=in_a, out_err=0, DONE on the cycle after accept (latency 1).
  - No bit_valid pulses for that request.
  - Illegal op with b=0 still runs the full 32 cycles.
- Undefined: every request takes the full RUN sequence.

Test Plan:
- SLL a=0x00000001 b=31 -> bit_out 0 for c=0..30, 1 at c=31; out_d=0x80000000, out_err=0, out_valid at T+33.
- SRL a=0x80000000 b=4 -> out_d=0x08000000; SRA same operands -> out_d=0xF8000000; SRA a=0x7FFFFFF0 b=4 -> 0x07FFFFFF.
- Backpressure: out_ready held low 10 cycles after DONE -> out_valid/out_d stable 10 cycles, in_ready=0; release -> IDLE next edge, new request accepted.
- flush at c=12 of SRL a=0xFFFFFFFF b=1 -> IDLE next cycle, no out_valid; next SLL a=0x3 b=1 gives 0x00000006.
- rstn low at c=20 -> same-cycle out_valid=0, bit_valid=0, in_ready=1; op=0011 a=0x1 b=0 after reset -> out_err=1, out_d=0x00000001.
- b=0 SLL a=0xDEADBEEF -> out_d=0xDEADBEEF: latency 33 without bypass, 1 with NANOV_SHIFT_SEQ_BYPASS_EN.
